// File: rtl/miriscv_periph.sv
// Peripheral block for the miriscv core: address decode, LED register and a
// scanning interrupt controller. Optional macro MIRISCV_PERIPH_LED_BE_EN makes
// LED writes honour byte enables; by default an LED write replaces all 32 bits.
module miriscv_periph #(
    parameter logic [31:0] RAM_SIZE = 32'd4096,
    parameter logic [31:0] LED_ADDR = 32'h8000_0000,
    parameter logic [31:0] SW_ADDR  = 32'h8000_1000
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [31:0] addr,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        we_m,
    output logic        req_m,
    output logic        we_d1,
    output logic [1:0]  rdsel,
    output logic [31:0] led_q,
    input  logic [31:0] mie,
    input  logic [31:0] int_req,
    input  logic        int_rst,
    output logic        irq,
    output logic [31:0] mcause,
    output logic [31:0] int_fin,
    output logic        dbg_state_o,
    output logic [4:0]  dbg_cnt_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } irq_state_e;

    irq_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] led_d;
    logic        mem_hit;
    logic        led_hit;
    logic        sw_hit;
    logic        led_we;
    logic [31:0] masked_req;

    // The core bus has no backpressure: req/we/be/wdata qualify an access in
    // the very cycle they are presented, and every target accepts it at once.
    assign mem_hit = (addr < RAM_SIZE);
    assign led_hit = (addr[31:2] == LED_ADDR[31:2]);
    assign sw_hit  = (addr[31:2] == SW_ADDR[31:2]);

    assign req_m  = req & mem_hit;
    assign we_m   = we & req & mem_hit;
    assign we_d1  = we & req & sw_hit;
    assign led_we = we & req & led_hit;

    always_comb begin
        rdsel = 2'b11;
        if (mem_hit) begin
            rdsel = 2'b00;
        end else if (led_hit) begin
            rdsel = 2'b01;
        end else if (sw_hit) begin
            rdsel = 2'b10;
        end
    end

`ifdef MIRISCV_PERIPH_LED_BE_EN
    always_comb begin
        led_d = led_q;
        if (led_we) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    led_d[8*n +: 8] = wdata[8*n +: 8];
                end
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^be;

    always_comb begin
        led_d = led_q;
        if (led_we) begin
            led_d = wdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            led_q <= 32'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign masked_req = int_req & mie;

    // Round-robin scan: one line is inspected per cycle, so the controller
    // never needs a priority encoder across all 32 lines.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            irq     <= 1'b0;
            mcause  <= 32'b0;
            int_fin <= 32'b0;
        end else begin
            int_fin <= 32'b0;
            case (state_q)
                IDLE: begin
                    if (masked_req[cnt_q]) begin
                        state_q <= PENDING;
                        irq     <= 1'b1;
                        mcause  <= {27'b0, cnt_q};
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                PENDING: begin
                    if (int_rst) begin
                        state_q <= IDLE;
                        irq     <= 1'b0;
                        mcause  <= 32'b0;
                        int_fin <= 32'b1 << cnt_q;
                        cnt_q   <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_miriscv_periph.sv
// Directed bench for miriscv_periph: decode table plus hand-written sequences
// for the LED register and the interrupt controller.
module tb_miriscv_periph;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we_m;
    logic        req_m;
    logic        we_d1;
    logic [1:0]  rdsel;
    logic [31:0] led_q;
    logic [31:0] mie;
    logic [31:0] int_req;
    logic        int_rst;
    logic        irq;
    logic [31:0] mcause;
    logic [31:0] int_fin;
    logic        dbg_state_o;
    logic [4:0]  dbg_cnt_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    miriscv_periph dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .addr       (addr),
        .req        (req),
        .we         (we),
        .be         (be),
        .wdata      (wdata),
        .we_m       (we_m),
        .req_m      (req_m),
        .we_d1      (we_d1),
        .rdsel      (rdsel),
        .led_q      (led_q),
        .mie        (mie),
        .int_req    (int_req),
        .int_rst    (int_rst),
        .irq        (irq),
        .mcause     (mcause),
        .int_fin    (int_fin),
        .dbg_state_o(dbg_state_o),
        .dbg_cnt_o  (dbg_cnt_o)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        req;
        logic        we;
        logic        exp_req_m;
        logic        exp_we_m;
        logic        exp_we_d1;
        logic [1:0]  exp_rdsel;
    } dec_vec_t;

    dec_vec_t dec_tab[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic led_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        addr  = a;
        req   = 1'b1;
        we    = 1'b1;
        be    = b;
        wdata = d;
        tick();
        req   = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        logic irq_seen;
        logic [31:0] fin_seen;
        logic [31:0] exp_led;

        rst_i   = 1'b1;
        addr    = 32'h0;
        req     = 1'b0;
        we      = 1'b0;
        be      = 4'h0;
        wdata   = 32'h0;
        mie     = 32'h0;
        int_req = 32'h0;
        int_rst = 1'b0;

        dec_tab[0] = '{32'h0000_0FFC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        dec_tab[1] = '{32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
        dec_tab[2] = '{32'h8000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
        dec_tab[3] = '{32'h8000_1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        dec_tab[4] = '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        dec_tab[5] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        dec_tab[6] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        dec_tab[7] = '{32'h8000_1004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
        dec_tab[8] = '{32'h8000_1002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
        dec_tab[9] = '{32'h8000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};

        tick();
        tick();
        check("reset_led_q",   led_q,   32'h0);
        check("reset_irq",     {31'b0, irq}, 32'h0);
        check("reset_mcause",  mcause,  32'h0);
        check("reset_int_fin", int_fin, 32'h0);
        check("reset_cnt",     {27'b0, dbg_cnt_o}, 32'h0);

        // Decode table applied while reset is held: decode must be unaffected.
        be    = 4'hF;
        wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            addr = dec_tab[i].addr;
            req  = dec_tab[i].req;
            we   = dec_tab[i].we;
            #1;
            check($sformatf("dec%0d_req_m", i), {31'b0, req_m}, {31'b0, dec_tab[i].exp_req_m});
            check($sformatf("dec%0d_we_m", i),  {31'b0, we_m},  {31'b0, dec_tab[i].exp_we_m});
            check($sformatf("dec%0d_we_d1", i), {31'b0, we_d1}, {31'b0, dec_tab[i].exp_we_d1});
            check($sformatf("dec%0d_rdsel", i), {30'b0, rdsel}, {30'b0, dec_tab[i].exp_rdsel});
        end
        // Last vector is an LED write strobe; reset must win at this edge.
        tick();
        check("reset_overrides_led_write", led_q, 32'h0);
        req = 1'b0;
        we  = 1'b0;
        rst_i = 1'b0;

        // LED register writes
        led_write(32'h8000_0000, 4'b0011, 32'hAABB_CCDD);
`ifdef MIRISCV_PERIPH_LED_BE_EN
        exp_led = 32'h0000_CCDD;
`else
        exp_led = 32'hAABB_CCDD;
`endif
        check("led_write_be0011", led_q, exp_led);
        led_write(32'h8000_0002, 4'b1100, 32'h1122_3344);
`ifdef MIRISCV_PERIPH_LED_BE_EN
        exp_led = 32'h1122_CCDD;
`else
        exp_led = 32'h1122_3344;
`endif
        check("led_write_be1100", led_q, exp_led);
        req = 1'b0;
        tick();
        check("led_hold", led_q, exp_led);
        addr = 32'h8000_0000;
        req  = 1'b1;
        we   = 1'b0;
        wdata = 32'h0;
        tick();
        check("led_read_no_write", led_q, exp_led);
        req = 1'b0;

        // Interrupt on line 5: irq rises on the 6th edge after reset.
        do_reset();
        mie     = 32'hFFFF_FFFF;
        int_req = 32'h0000_0020;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) check("irq_before_6th_edge", {31'b0, irq}, 32'h0);
        end
        check("irq_6th_edge", {31'b0, irq}, 32'h1);
        check("mcause_5",     mcause, 32'd5);
        int_req = 32'h0;
        mie     = 32'h0;
        tick();
        tick();
        tick();
        check("pending_irq_frozen",    {31'b0, irq}, 32'h1);
        check("pending_mcause_frozen", mcause, 32'd5);
        check("pending_cnt_frozen",    {27'b0, dbg_cnt_o}, 32'd5);
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
        check("int_fin_pulse",    int_fin, 32'h0000_0020);
        check("irq_cleared",      {31'b0, irq}, 32'h0);
        check("mcause_cleared",   mcause, 32'h0);
        check("cnt_after_ack",    {27'b0, dbg_cnt_o}, 32'd6);
        tick();
        check("int_fin_one_cycle", int_fin, 32'h0);

        // Masked line never interrupts; scan wraps; int_rst in IDLE ignored.
        do_reset();
        mie      = ~32'h0000_0008;
        int_req  = 32'h0000_0008;
        irq_seen = 1'b0;
        fin_seen = 32'h0;
        for (int e = 1; e <= 70; e++) begin
            int_rst = (e == 10);
            tick();
            irq_seen = irq_seen | irq;
            fin_seen = fin_seen | int_fin;
            if (e == 10) check("cnt_idle_int_rst", {27'b0, dbg_cnt_o}, 32'd10);
            if (e == 31) check("cnt_31", {27'b0, dbg_cnt_o}, 32'd31);
            if (e == 32) check("cnt_wrap_0", {27'b0, dbg_cnt_o}, 32'd0);
            if (e == 64) check("cnt_wrap_again", {27'b0, dbg_cnt_o}, 32'd0);
        end
        int_rst = 1'b0;
        check("masked_no_irq", {31'b0, irq_seen}, 32'h0);
        check("idle_no_int_fin", fin_seen, 32'h0);

        // Reset while PENDING with LED nonzero, int_rst also high.
        do_reset();
        mie     = 32'hFFFF_FFFF;
        int_req = 32'h0000_0004;
        led_write(32'h8000_0000, 4'hF, 32'h1234_5678);
        tick();
        tick();
        check("pend_line2_irq",    {31'b0, irq}, 32'h1);
        check("pend_line2_mcause", mcause, 32'd2);
        check("pend_line2_led",    led_q, 32'h1234_5678);
        rst_i   = 1'b1;
        int_rst = 1'b1;
        tick();
        rst_i   = 1'b0;
        int_rst = 1'b0;
        int_req = 32'h0;
        check("rst_pend_irq",     {31'b0, irq}, 32'h0);
        check("rst_pend_mcause",  mcause, 32'h0);
        check("rst_pend_led",     led_q, 32'h0);
        check("rst_pend_int_fin", int_fin, 32'h0);
        check("rst_pend_state",   {31'b0, dbg_state_o}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/miriscv_periph.md
MIRISCV_PERIPH -- requirements
Module: miriscv_periph

Interface
REQ-001 Parameter RAM_SIZE, default 4096, byte size of data memory window starting at address 0.
REQ-002 Parameter LED_ADDR, default 32'h8000_0000, word address of LED register.
REQ-003 Parameter SW_ADDR, default 32'h8000_1000, word address of switch controller.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 addr  input  32  core data address.
REQ-007 req  input  1  core data request.
REQ-008 we  input  1  core write enable.
REQ-009 be  input  4  core byte enables.
REQ-010 wdata  input  32  core write data.
REQ-011 we_m / req_m  output  1 each  memory write enable / request.
REQ-012 we_d1  output  1  switch-controller write strobe.
REQ-013 rdsel  output  2  read-mux select: 00 memory, 01 LED, 10 switch, 11 none.
REQ-014 led_q  output  32  LED register contents.
REQ-015 mie  input  32  per-line interrupt enable mask.
REQ-016 int_req  input  32  interrupt request lines, level.
REQ-017 int_rst  input  1  interrupt-serviced pulse from core.
REQ-018 irq  output  1  interrupt pending to core.
REQ-019 mcause  output  32  cause of pending interrupt.
REQ-020 int_fin  output  32  one-hot completion pulse to requesting device.

Function
REQ-021 Memory hit: addr < RAM_SIZE; LED hit: addr[31:2]==LED_ADDR[31:2]; switch hit: addr[31:2]==SW_ADDR[31:2]; otherwise no hit.
REQ-022 Decode is combinational: req_m=req&mem hit, we_m=we&req&mem hit, we_d1=we&req&switch hit; internal LED strobe = we&req&LED hit.
REQ-023 rdsel reflects the hit region combinationally, independent of req.
REQ-024 LED register: on LED strobe, byte n written with wdata[8n+7:8n] where be[n]=1; otherwise holds; led_q driven directly from the register.
REQ-025 Interrupt controller holds a 5-bit scan index cnt and state IDLE/PENDING.
REQ-026 IDLE: if (int_req & mie)[cnt]=1, next cycle enter PENDING with irq=1 and mcause={27'b0,cnt}; else cnt increments by 1, wrapping 31->0.
REQ-027 PENDING: cnt, irq and mcause frozen regardless of int_req/mie changes.
REQ-028 PENDING with int_rst=1: next cycle int_fin has bit cnt set for exactly one cycle, irq=0, mcause=0, cnt increments, state IDLE.
REQ-029 int_rst in IDLE ignored; int_fin zero except per REQ-028.
REQ-030 Interrupt latency: masked request at index cnt asserts irq on the following edge; worst case 32 cycles from request assertion.

Reset
REQ-031 rst_i=1 at an edge: led_q=0, cnt=0, state IDLE, irq=0, mcause=0, int_fin=0; reset overrides strobes and int_rst in the same cycle; combinational decode outputs unaffected.

Configuration
REQ-032 Macro MIRISCV_PERIPH_LED_BE_EN defined: LED writes honour be per REQ-024; undefined: LED strobe writes all 32 bits, be ignored.

Verification
REQ-033 addr=0x0000_0FFC, req=1, we=1 -> req_m=1, we_m=1, rdsel=00, we_d1=0; addr=0x0000_1000 -> req_m=0, rdsel=11.
REQ-034 addr=0x8000_0000, req=1, we=1, be=4'b0011, wdata=0xAABB_CCDD -> next cycle led_q=0x0000_CCDD (0xAABB_CCDD without macro).
REQ-035 addr=0x8000_1000, req=1, we=1 -> we_d1=1, rdsel=10; same with req=0 -> we_d1=0, rdsel=10.
REQ-036 After reset, mie=0xFFFF_FFFF, int_req=1<<5 -> irq=1 on 6th edge, mcause=5; int_rst pulse -> int_fin=0x20 one cycle, irq=0.
REQ-037 int_req bit 3 set with mie bit 3 clear -> irq never asserts; cnt wraps 31->0 continuously.
REQ-038 rst_i asserted while PENDING with led_q nonzero -> next cycle irq=0, mcause=0, led_q=0.
